// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control slice.
//   state_t : sequencer states RUN / FLUSH / HALT
//   REG_AW  : default register address width
//   REG_X0  : x0 register address (hard-wired zero, never a hazard source)
package hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [4:0]  REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector; shared with the forwarding path.
// Ports:
//   rs1, rs2 : source registers of the instruction in ID
//   memRead  : instruction in EX is a load
//   regRd    : destination register of the instruction in EX
//   lu       : load result is needed by ID before it can be forwarded
module load_use_detect #(
  parameter int unsigned AW = hazard_pkg::REG_AW
) (
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          memRead,
  input  logic [AW-1:0] regRd,
  output logic          lu
);
  import hazard_pkg::*;

  // Writes to x0 are discarded, so a load into x0 never creates a dependency.
  assign lu = memRead && (regRd != AW'(REG_X0)) && ((regRd == rs1) || (regRd == rs2));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer for the 5-stage core: load-use stall, branch flush,
// ecall/ebreak halt with external resume.
// Ports:
//   clk, rst                       : clock, async active-low reset
//   IF_ID_rs1/rs2                  : sources of the instruction in ID
//   ID_EXE_memRead/regRd           : load flag and rd of the instruction in EX
//   branch_taken, halt_req, resume : control events
//   pc_write, IF_ID_write          : PC / IF-ID load enables
//   ID_EXE_bubble, flush, halted   : NOP insert, wrong-path squash, frozen flag
//   stall_count, flush_count       : saturating perf counters (HAZARD_PERF_EN)
// Outputs are combinational from state and inputs.
// Build option: define HAZARD_PERF_EN to add the perf counters.
module hazard_ctrl_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_AW       = hazard_pkg::REG_AW
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] IF_ID_rs1,
  input  logic [REG_AW-1:0] IF_ID_rs2,
  input  logic              ID_EXE_memRead,
  input  logic [REG_AW-1:0] ID_EXE_regRd,
  input  logic              branch_taken,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              ID_EXE_bubble,
  output logic              flush,
  output logic              halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);
  import hazard_pkg::*;

  localparam int unsigned CW = 2;

  state_t        stateQ, stateNext;
  logic [CW-1:0] cntQ, cntNext;
  logic          lu;

  load_use_detect #(.AW(REG_AW)) u_lu (
    .rs1     (IF_ID_rs1),
    .rs2     (IF_ID_rs2),
    .memRead (ID_EXE_memRead),
    .regRd   (ID_EXE_regRd),
    .lu      (lu)
  );

  // State register; reset aborts any flush or halt in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= RUN;
      cntQ   <= '0;
    end else begin
      stateQ <= stateNext;
      cntQ   <= cntNext;
    end
  end

  // Next state and control outputs.
  always_comb begin
    stateNext     = stateQ;
    cntNext       = cntQ;
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EXE_bubble = 1'b0;
    flush         = 1'b0;
    halted        = 1'b0;

    case (stateQ)
      RUN: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            stateNext = FLUSH;
            cntNext   = CW'(FLUSH_CYCLES - 2);
          end
        end else if (lu) begin
          pc_write      = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EXE_bubble = 1'b1;
        end else if (halt_req) begin
          pc_write      = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EXE_bubble = 1'b1;
          stateNext     = HALT;
        end
      end
      // Everything in flight is wrong-path: ignore all events.
      FLUSH: begin
        flush = 1'b1;
        if (cntQ == '0) stateNext = RUN;
        else            cntNext   = cntQ - CW'(1);
      end
      // Resume cycle releases fetch while the ecall retires as a bubble.
      HALT: begin
        halted        = 1'b1;
        ID_EXE_bubble = 1'b1;
        if (resume) begin
          stateNext = RUN;
        end else begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
        end
      end
      default: stateNext = RUN;
    endcase

    if (!rst) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EXE_bubble = 1'b0;
      flush         = 1'b0;
      halted        = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating stall / flush cycle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1))     flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Inputs change on the falling edge and
// outputs are checked 1 time unit later; state advances on the rising edge.
// Output vector order: {pc_write, IF_ID_write, ID_EXE_bubble, flush, halted}.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EXE_regRd;
  logic       ID_EXE_memRead, branch_taken, halt_req, resume;
  logic       pc_write, IF_ID_write, ID_EXE_bubble, flush, halted;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.FLUSH_CYCLES(2), .REG_AW(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .ID_EXE_memRead (ID_EXE_memRead),
    .ID_EXE_regRd   (ID_EXE_regRd),
    .branch_taken   (branch_taken),
    .halt_req       (halt_req),
    .resume         (resume),
    .pc_write       (pc_write),
    .IF_ID_write    (IF_ID_write),
    .ID_EXE_bubble  (ID_EXE_bubble),
    .flush          (flush),
    .halted         (halted)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic [4:0] exp);
    check(tag, 32'({pc_write, IF_ID_write, ID_EXE_bubble, flush, halted}), 32'(exp));
  endtask

  // Next falling edge: apply one vector and let it settle.
  task automatic step(input logic br, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic hr, input logic rs);
    @(negedge clk);
    branch_taken   = br;
    ID_EXE_memRead = mr;
    ID_EXE_regRd   = rd;
    IF_ID_rs1      = r1;
    IF_ID_rs2      = r2;
    halt_req       = hr;
    resume         = rs;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    branch_taken = 0; ID_EXE_memRead = 0; ID_EXE_regRd = 0;
    IF_ID_rs1 = 0; IF_ID_rs2 = 0; halt_req = 0; resume = 0;
    #1;
    checkOut("reset_outputs", 5'b00000);
`ifdef HAZARD_PERF_EN
    check("reset_stall_cnt", stall_count, 32'd0);
    check("reset_flush_cnt", flush_count, 32'd0);
`endif
    @(negedge clk); rst = 1'b1; #1;
    checkOut("run_idle", 5'b11000);

    // Load-use through rs2, then through rs1.
    step(0, 1, 5'd5, 5'd1, 5'd5, 0, 0); checkOut("lu_rs2", 5'b00100);
    step(0, 0, 5'd0, 5'd1, 5'd5, 0, 0); checkOut("lu_rs2_after", 5'b11000);
    step(0, 1, 5'd7, 5'd7, 5'd2, 0, 0); checkOut("lu_rs1", 5'b00100);
    step(0, 0, 5'd7, 5'd7, 5'd2, 0, 0); checkOut("match_no_load", 5'b11000);
    step(0, 1, 5'd0, 5'd0, 5'd3, 0, 0); checkOut("x0_exempt", 5'b11000);

    // Branch: two flush cycles; lu in the second is ignored.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("br_flush1", 5'b11010);
    step(0, 1, 5'd5, 5'd0, 5'd5, 0, 0); checkOut("br_flush2_lu_ign", 5'b11010);
    step(0, 1, 5'd5, 5'd0, 5'd5, 0, 0); checkOut("br_back_run_lu", 5'b00100);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("br_idle", 5'b11000);

    // Branch wins over a simultaneous load-use.
    step(1, 1, 5'd5, 5'd5, 5'd0, 0, 0); checkOut("br_and_lu", 5'b11010);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("br_and_lu_f2", 5'b11010);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("br_and_lu_run", 5'b11000);

    // Halt held 10 cycles, resume releases once, halt_req ignored then.
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0); checkOut("halt_req", 5'b00100);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut($sformatf("halted_%0d", i), 5'b00101);
    end
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("halt_br_ignored", 5'b00101);
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 1); checkOut("resume", 5'b11101);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("after_resume", 5'b11000);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("no_rehalt", 5'b11000);

    // Reset during the first flush cycle; release before the next rising edge.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("pre_rst_branch", 5'b11010);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("rst_flush_cyc1", 5'b11010);
    rst = 1'b0; #1;
    checkOut("rst_mid_flush", 5'b00000);
    #1 rst = 1'b1; #1;
    checkOut("rst_flush_released", 5'b11000);
`ifdef HAZARD_PERF_EN
    check("rst_stall_cnt", stall_count, 32'd0);
    check("rst_flush_cnt", flush_count, 32'd0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check("flush_cnt_1", flush_count, 32'd1);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check("flush_cnt_2", flush_count, 32'd2);
    step(0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check("stall_cnt_1", stall_count, 32'd1);
`endif

    // Reset while halted.
    step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0); checkOut("halt_req2", 5'b00100);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOut("halted2", 5'b00101);
    rst = 1'b0; #1;
    checkOut("rst_mid_halt", 5'b00000);
    #1 rst = 1'b1; #1;
    checkOut("rst_halt_released", 5'b11000);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
